// File: rtl/aes_ctrl_defs.sv
// Shared definitions for the AES-128 round-key controller: FSM encoding,
// round-index width, and the key-schedule helpers used by the expander.
package aes_ctrl_defs;

    localparam int AES_128_NUM_ROUNDS = 10;
    localparam int RND_W              = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_EXPAND  = 2'd2,
        ST_AVAIL   = 2'd3
    } ctrl_state_t;

    // Forward S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        // Byte b lives at bit offset (255-b)*8; ~b is 255-b for 8 bits.
        idx = {~b, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One step of the AES-128 schedule: round key rnd from round key rnd-1.
    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [RND_W-1:0] rnd);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/my_aes_key_mem.sv
// AES-128 key expander: on init it emits round keys 0..10, one per cycle,
// each tagged with roundkey_valid and its round index.
module my_aes_key_mem
    import aes_ctrl_defs::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic [127:0]     key,
    output logic             ready,
    output logic             roundkey_valid,
    output logic [RND_W-1:0] round,
    output logic [127:0]     roundkey
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(AES_128_NUM_ROUNDS);

    logic busy;

    assign ready = ~busy;

    // Load the cipher key as round 0, then derive one round key per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            round          <= '0;
            roundkey       <= '0;
            roundkey_valid <= 1'b0;
        end else if (!busy) begin
            if (init) begin
                busy           <= 1'b1;
                round          <= '0;
                roundkey       <= key;
                roundkey_valid <= 1'b1;
            end
        end else if (round == LAST_RND) begin
            busy           <= 1'b0;
            roundkey_valid <= 1'b0;
        end else begin
            round    <= round + 1'b1;
            roundkey <= next_round_key(roundkey, round + 1'b1);
        end
    end

endmodule

// File: rtl/aes_round_key_ctrl.sv
// Round-key controller: accepts a cipher key, waits for the engine lock to
// clear, runs the expander and keeps all round keys in a readable store.
//
// Key handshake: key_in is taken on every rising edge where
// key_valid && key_ready. key_ready is a registered state output and never
// depends on key_valid in the same cycle; key_valid may stay high while
// key_ready is low, and nothing is taken until both are high at an edge.
module aes_round_key_ctrl
    import aes_ctrl_defs::*;
#(
    parameter int NUM_ROUNDS = AES_128_NUM_ROUNDS,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             eng_lock,
    output logic             key_avail,
    output logic             expand_done,
    input  logic [RND_W-1:0] rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic [1:0]       dbg_state
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    ctrl_state_t      state;
    logic [KEY_W-1:0] work_key;
    logic             exp_init;
    logic             exp_ready;
    logic             rk_valid;
    logic [RND_W-1:0] rk_round;
    logic [KEY_W-1:0] rk_key;
    logic [KEY_W-1:0] store [0:NUM_ROUNDS];

    assign dbg_state = state;

    my_aes_key_mem u_key_mem (
        .clk            (clk),
        .reset_n        (~reset),
        .init           (exp_init),
        .key            (work_key),
        .ready          (exp_ready),
        .roundkey_valid (rk_valid),
        .round          (rk_round),
        .roundkey       (rk_key)
    );

    // Control FSM; every output it drives is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            work_key    <= '0;
            exp_init    <= 1'b0;
            key_ready   <= 1'b1;
            key_avail   <= 1'b0;
            expand_done <= 1'b0;
        end else begin
            exp_init    <= 1'b0;
            expand_done <= 1'b0;
            case (state)
                ST_IDLE, ST_AVAIL: begin
                    if (key_valid && key_ready) begin
                        work_key  <= key_in;
                        key_ready <= 1'b0;
                        key_avail <= 1'b0;
                        state     <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!eng_lock && exp_ready) begin
                        exp_init <= 1'b1;
                        state    <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    // The engine cannot hold the lock here, so eng_lock is not consulted.
                    if (rk_valid && rk_round == LAST_RND) begin
                        key_ready   <= 1'b1;
                        key_avail   <= 1'b1;
                        expand_done <= 1'b1;
                        state       <= ST_AVAIL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture each round key as the expander presents it; reset wipes partial results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store[i] <= '0;
            end
        end else if (rk_valid && state == ST_EXPAND && rk_round <= LAST_RND) begin
            store[rk_round] <= rk_key;
        end
    end

    // Registered read port; indices past the last round read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_key <= '0;
        end else if (rd_round <= LAST_RND) begin
            rd_key <= store[rd_round];
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: tb/tb_aes_round_key_ctrl.sv
// Bench for aes_round_key_ctrl: FIPS-197 vectors, random keys, lock stalls,
// rekeying, refused keys, out-of-range reads and reset mid-expansion.
module tb_aes_round_key_ctrl;
    import aes_ctrl_defs::*;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         eng_lock = 1'b0;
    logic [3:0]   rd_round = '0;
    logic         key_ready;
    logic         key_avail;
    logic         expand_done;
    logic [127:0] rd_key;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_key_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .eng_lock    (eng_lock),
        .key_avail   (key_avail),
        .expand_done (expand_done),
        .rd_round    (rd_round),
        .rd_key      (rd_key),
        .dbg_state   (dbg_state)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam int           DONE_LAT = 13;

    // ---------------- scoreboard ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model_rk [0:10];
    logic [7:0]   sb [0:255];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-oriented key expansion, w[0..43], four words per round key.
    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic clear_model();
        for (int r = 0; r <= 10; r++) model_rk[r] = '0;
    endtask

    function automatic logic [127:0] model_read(input logic [3:0] r);
        return (r <= 4'd10) ? model_rk[r] : 128'h0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"},   128'(key_ready),   128'h1);
        check({tag, "_key_avail"},   128'(key_avail),   128'h0);
        check({tag, "_expand_done"}, 128'(expand_done), 128'h0);
        check({tag, "_rd_key"},      rd_key,            128'h0);
    endtask

    // Offers k for one edge; acc is the index of the accepting edge.
    task automatic send_key(input string tag, input logic [127:0] k, output int acc);
        @(negedge clk);
        check({tag, "_ready_offer"}, 128'(key_ready), 128'h1);
        key_in    = k;
        key_valid = 1'b1;
        acc       = cyc + 1;
        @(negedge clk);
        key_valid = 1'b0;
        check({tag, "_ready_after"}, 128'(key_ready), 128'h0);
        check({tag, "_avail_after"}, 128'(key_avail), 128'h0);
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (expand_done) break;
        end
        if (expand_done) begin
            check({tag, "_latency"}, 128'(cyc - base), 128'(DONE_LAT));
            check({tag, "_avail"},   128'(key_avail), 128'h1);
            check({tag, "_ready"},   128'(key_ready), 128'h1);
            @(negedge clk);
            check({tag, "_done_pulse"}, 128'(expand_done), 128'h0);
        end else begin
            check({tag, "_timeout"}, 128'(cyc - base), 128'(DONE_LAT));
        end
    endtask

    task automatic read_one(input string tag, input logic [3:0] r, input logic [127:0] exp);
        @(negedge clk);
        rd_round = r;
        exp_q.push_back(exp);
        @(negedge clk);
        check(tag, rd_key, exp_q.pop_front());
    endtask

    // Back-to-back random reads, one new index per cycle.
    task automatic read_sweep(input string tag, input int n);
        logic [3:0] r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) check(tag, rd_key, exp_q.pop_front());
            r = 4'($urandom_range(0, 15));
            rd_round = r;
            exp_q.push_back(model_read(r));
        end
        @(negedge clk);
        check(tag, rd_key, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int base;
        int hold;
        logic [127:0] k;

        build_sbox();

        // Reset values while held and after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // FIPS-197 vector.
        expand_model(FIPS_KEY);
        send_key("fips", FIPS_KEY, acc);
        wait_done("fips", acc);
        read_one("fips_r0", 4'd0, FIPS_KEY);
        read_one("fips_r1", 4'd1, FIPS_R1);
        read_one("fips_r10", 4'd10, FIPS_R10);
        read_one("oor_11", 4'd11, 128'h0);
        read_one("oor_15", 4'd15, 128'h0);
        read_sweep("fips_sweep", 20);

        // Rekey in AVAIL while the engine holds its lock, then stall 20 cycles.
        expand_model(128'h0);
        eng_lock = 1'b1;
        send_key("rekey", 128'h0, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_ready", 128'(key_ready), 128'h0);
            check("stall_done",  128'(expand_done), 128'h0);
            check("stall_state", 128'(dbg_state), 128'(ST_PENDING));
        end
        base = cyc;
        eng_lock = 1'b0;
        wait_done("stall", base);
        read_one("zero_r10", 4'd10, ZERO_R10);
        read_sweep("zero_sweep", 16);

        // A key offered during expansion is refused.
        expand_model(FIPS_KEY);
        send_key("refuse", FIPS_KEY, acc);
        repeat (2) @(negedge clk);
        key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("refuse_ready", 128'(key_ready), 128'h0);
        end
        key_valid = 1'b0;
        wait_done("refuse", acc);
        read_one("refuse_r10", 4'd10, FIPS_R10);

        // Random keys with random lock hold times.
        for (int n = 0; n < 4; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_model(k);
            eng_lock = 1'b1;
            send_key("rand", k, acc);
            hold = $urandom_range(0, 6);
            repeat (hold) @(negedge clk);
            base = cyc;
            eng_lock = 1'b0;
            wait_done("rand", base);
            read_sweep("rand_sweep", 16);
        end

        // Reset in the middle of expansion, around round 5.
        send_key("midrst", FIPS_KEY, acc);
        for (int i = 0; i < 20 && cyc < acc + 7; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        read_one("midrst_r0", 4'd0, 128'h0);
        read_one("midrst_r5", 4'd5, 128'h0);
        expand_model(FIPS_KEY);
        send_key("reload", FIPS_KEY, acc);
        wait_done("reload", acc);
        read_one("reload_r0", 4'd0, FIPS_KEY);
        read_one("reload_r1", 4'd1, FIPS_R1);
        read_one("reload_r10", 4'd10, FIPS_R10);
        read_sweep("reload_sweep", 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
